window_stream_buffer: RTL

- Parametrised sliding-window generator for the raster pixel stream. Generalises the per-stage shift-register plus FIFO row buffers used ahead of the sobel/flood stages into one block.
- Configurable window size, data width and frame size; window positions outside the frame are replaced by a pad value.
- Adds a valid/ready input handshake and an end-of-frame flush, so every pixel of the frame gets exactly one centred window.
- Sits between a producer stage (rgb2i, threshold, flood) and any window kernel.

---
 rtl/window_stream_buffer_pkg.sv | 15 +
 rtl/window_border_mask.sv | 44 ++++
 rtl/window_stream_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_stream_buffer_pkg.sv
// Shared types and helpers for the sliding-window stream buffer.
package window_stream_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Element slot of window position (r,c) inside the packed window vector.
    function automatic int win_pack_idx(input int r, input int c, input int win_w);
        return r * win_w + c;
    endfunction

endpackage

// File: rtl/window_border_mask.sv
// Replaces window elements whose frame position lies outside the frame with the pad value.
module window_border_mask
    import window_stream_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    WIN_W        = 3,
    parameter int                    WIN_H        = 3,
    parameter int                    FRAME_WIDTH  = 640,
    parameter int                    FRAME_HEIGHT = 480,
    parameter int                    LOC_SIZE     = 11,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic [LOC_SIZE-1:0]               cx,
    input  logic [LOC_SIZE-1:0]               cy,
    input  logic [WIN_W*WIN_H*DATA_WIDTH-1:0] raw_window,
    output logic [WIN_W*WIN_H*DATA_WIDTH-1:0] masked_window
);

    localparam int HW = WIN_W / 2;
    localparam int HH = WIN_H / 2;

    int px;
    int py;

    // Per-element bounds test; also catches row wrap-around at the left/right edges.
    always_comb begin
        masked_window = raw_window;
        px = 0;
        py = 0;
        for (int r = 0; r < WIN_H; r++) begin
            for (int c = 0; c < WIN_W; c++) begin
                px = int'(cx) + c - HW;
                py = int'(cy) + r - HH;
                if (px < 0 || px >= FRAME_WIDTH || py < 0 || py >= FRAME_HEIGHT) begin
                    masked_window[win_pack_idx(r, c, WIN_W)*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
                end else begin
                    masked_window[win_pack_idx(r, c, WIN_W)*DATA_WIDTH +: DATA_WIDTH] =
                        raw_window[win_pack_idx(r, c, WIN_W)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/window_stream_buffer.sv
// Sliding-window generator: buffers a raster stream and emits one border-masked,
// centred window per frame pixel, flushing the tail with pad pixels at end of frame.
module window_stream_buffer
    import window_stream_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    WIN_W        = 3,
    parameter int                    WIN_H        = 3,
    parameter int                    FRAME_WIDTH  = 640,
    parameter int                    FRAME_HEIGHT = 480,
    parameter int                    LOC_SIZE     = 11,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sof,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    output logic                              out_sof,
    output logic                              out_eof,
    output logic [LOC_SIZE-1:0]               out_x,
    output logic [LOC_SIZE-1:0]               out_y,
    output logic [WIN_W*WIN_H*DATA_WIDTH-1:0] out_window,
    output logic                              frame_err
);

    localparam int HW       = WIN_W / 2;
    localparam int HH       = WIN_H / 2;
    localparam int D        = HH * FRAME_WIDTH + HW;
    localparam int N        = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int LINE_LEN = (WIN_H - 1) * FRAME_WIDTH + WIN_W;
    localparam int CNT_W    = $clog2(N + 1);
    localparam int WIN_BITS = WIN_W * WIN_H * DATA_WIDTH;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [CNT_W-1:0]      flush_q, flush_d;
    logic [LOC_SIZE-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic [LOC_SIZE-1:0]   cx_next_s, cy_next_s;
    logic                  accept_s, shift_s, emit_s;
    logic [DATA_WIDTH-1:0] shift_val_s;
    logic [DATA_WIDTH-1:0] line_q [LINE_LEN];
    logic [DATA_WIDTH-1:0] line_d [LINE_LEN];
    logic [WIN_BITS-1:0]   raw_window_s, masked_window_s;

    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic [LOC_SIZE-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    logic [WIN_BITS-1:0]   out_window_q, out_window_d;
    logic                  frame_err_q, frame_err_d;

    assign accept_s   = in_valid & in_ready_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_window = out_window_q;
    assign frame_err  = frame_err_q;

    // Raster successor of the centre coordinate that is emitted next.
    always_comb begin
        if (cx_q == LOC_SIZE'(FRAME_WIDTH - 1)) begin
            cx_next_s = '0;
            cy_next_s = (cy_q == LOC_SIZE'(FRAME_HEIGHT - 1)) ? '0 : cy_q + LOC_SIZE'(1);
        end else begin
            cx_next_s = cx_q + LOC_SIZE'(1);
            cy_next_s = cy_q;
        end
    end

    // Frame sequencing: accept, emit decision, restart on early sof, flush.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        flush_d     = flush_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        shift_s     = 1'b0;
        emit_s      = 1'b0;
        shift_val_s = in_data;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_sof) begin
                    shift_s = 1'b1;
                    n_d     = CNT_W'(1);
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = ST_STREAM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (accept_s && in_sof && (n_q != '0)) begin
                    frame_err_d = 1'b1;
                    shift_s     = 1'b1;
                    n_d         = CNT_W'(1);
                    cx_d        = '0;
                    cy_d        = '0;
                end else if (accept_s) begin
                    shift_s = 1'b1;
                    n_d     = n_q + CNT_W'(1);
                    if (n_q >= CNT_W'(D)) begin
                        emit_s = 1'b1;
                        cx_d   = cx_next_s;
                        cy_d   = cy_next_s;
                    end else begin
                        emit_s = 1'b0;
                    end
                    if (n_q == CNT_W'(N - 1)) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                shift_s     = 1'b1;
                shift_val_s = PAD_VALUE;
                emit_s      = 1'b1;
                cx_d        = cx_next_s;
                cy_d        = cy_next_s;
                flush_d     = flush_q + CNT_W'(1);
                state_d     = (flush_q == CNT_W'(D - 1)) ? ST_IDLE : ST_FLUSH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d != ST_FLUSH);
        out_valid_d = emit_s;
        out_sof_d   = emit_s && (cx_q == '0) && (cy_q == '0);
        out_eof_d   = emit_s && (cx_q == LOC_SIZE'(FRAME_WIDTH - 1)) &&
                      (cy_q == LOC_SIZE'(FRAME_HEIGHT - 1));
        out_x_d     = emit_s ? cx_q : out_x_q;
        out_y_d     = emit_s ? cy_q : out_y_q;
    end

    // Delay line equivalent to WIN_H rows of WIN_W taps chained through
    // (FRAME_WIDTH-WIN_W)-deep row FIFOs; index 0 holds the newest pixel.
    always_comb begin
        line_d = line_q;
        if (shift_s) begin
            line_d[0] = shift_val_s;
            for (int i = 1; i < LINE_LEN; i++) begin
                line_d[i] = line_q[i-1];
            end
        end else begin
            line_d = line_q;
        end
    end

    for (genvar r = 0; r < WIN_H; r++) begin : g_row
        for (genvar c = 0; c < WIN_W; c++) begin : g_col
            assign raw_window_s[win_pack_idx(r, c, WIN_W)*DATA_WIDTH +: DATA_WIDTH] =
                line_d[(WIN_H - 1 - r) * FRAME_WIDTH + (WIN_W - 1 - c)];
        end
    end

    window_border_mask #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WIN_W        (WIN_W),
        .WIN_H        (WIN_H),
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .LOC_SIZE     (LOC_SIZE),
        .PAD_VALUE    (PAD_VALUE)
    ) u_mask (
        .cx            (cx_q),
        .cy            (cy_q),
        .raw_window    (raw_window_s),
        .masked_window (masked_window_s)
    );

    // Output window holds its last value between pulses.
    always_comb begin
        out_window_d = emit_s ? masked_window_s : out_window_q;
    end

    // Pixel storage needs no reset: stale contents are always masked.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    // Control and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            flush_q      <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_window_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            flush_q      <= flush_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_window_q <= out_window_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule
